// File: rtl/nt_trig_pkg.sv
// Shared types for the Nt trigger pipeline: FSM state enum and the width of its encoding.
package nt_trig_pkg;

  localparam int STATE_W = 2;

  // Encoding 3 is unused; the FSM treats it as IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } nt_trig_state_e;

endpackage

// File: rtl/nt_pipe_stage.sv
// One W-bit pipeline register with async active-low reset, synchronous clear and advance enable.
module nt_pipe_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the pipeline into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nt_trigger_pipe.sv
// CH-channel NAND pipeline of DEPTH stages feeding a run-length trigger FSM.
// Optional build macro NT_TRIG_STICKY_EN keeps FIRED latched until clr_i or RSTB.
module nt_trigger_pipe
  import nt_trig_pkg::*;
#(
  parameter int CH     = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic               CLK,
  input  logic               RSTB,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [CH-1:0]      a_i,
  input  logic [CH-1:0]      b_i,
  output logic [CH-1:0]      out_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [STATE_W-1:0] state_o,
  output logic               trig_o
);

  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // pipe[0] is the combinational NAND; pipe[k] is the output of stage k-1.
  logic [DEPTH:0][CH-1:0] pipe;
  logic [DEPTH-1:0]       valid_sr;
  nt_trig_state_e         state_q;
  logic                   cond;

  assign pipe[0] = ~(a_i & b_i);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    nt_pipe_stage #(.W(CH)) u_stage (
      .clk  (CLK),
      .rst_n(RSTB),
      .en   (en_i),
      .clr  (clr_i),
      .d    (pipe[g]),
      .q    (pipe[g+1])
    );
  end

  assign out_o   = pipe[DEPTH];
  assign valid_o = valid_sr[DEPTH-1];
  assign state_o = state_q;

  // A shift of 1s rather than a counter: it saturates for free once full.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      valid_sr <= '0;
    end else if (clr_i) begin
      valid_sr <= '0;
    end else if (en_i) begin
      valid_sr <= (valid_sr << 1) | DEPTH'(1);
    end
  end

  // Qualifier is built from registered outputs only, so the FSM never sees a NAND glitch.
  assign cond = valid_o & (&out_o);

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      cnt_o   <= '0;
      trig_o  <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_o   <= '0;
      trig_o  <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        COUNT: begin
          if (!cond) begin
            state_q <= IDLE;
            cnt_o   <= '0;
            trig_o  <= 1'b0;
          end else if (cnt_o == THRESH_M1) begin
            state_q <= FIRED;
            cnt_o   <= THRESH_C;
            trig_o  <= 1'b1;
          end else if (cnt_o != '1) begin
            cnt_o <= cnt_o + CNT_ONE;
          end
        end
        FIRED: begin
`ifdef NT_TRIG_STICKY_EN
          state_q <= FIRED;
`else
          if (!cond) begin
            state_q <= IDLE;
            cnt_o   <= '0;
            trig_o  <= 1'b0;
          end
`endif
        end
        default: begin
          // IDLE, and the unused encoding which behaves exactly like it.
          if (cond) begin
            cnt_o <= CNT_ONE;
            if (THRESH == 1) begin
              state_q <= FIRED;
              trig_o  <= 1'b1;
            end else begin
              state_q <= COUNT;
              trig_o  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            cnt_o   <= '0;
            trig_o  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nt_trigger_pipe.sv
// Self-checking bench for nt_trigger_pipe: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_nt_trigger_pipe;

  localparam int CH     = 4;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 8;
  localparam int THRESH = 16;
  localparam int NVEC   = 22;

  logic             CLK;
  logic             RSTB;
  logic             en_i;
  logic             clr_i;
  logic [CH-1:0]    a_i;
  logic [CH-1:0]    b_i;
  logic [CH-1:0]    out_o;
  logic             valid_o;
  logic [CNT_W-1:0] cnt_o;
  logic [1:0]       state_o;
  logic             trig_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  nt_trigger_pipe #(
    .CH(CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)
  ) dut (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .en_i   (en_i),
    .clr_i  (clr_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .out_o  (out_o),
    .valid_o(valid_o),
    .cnt_o  (cnt_o),
    .state_o(state_o),
    .trig_o (trig_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Outputs are derived from history: the NAND results of the last DEPTH enabled cycles,
  // how many enabled cycles have elapsed, and the length of the current qualifying run.
  logic [CH-1:0] m_hist[$];
  int            m_en_cnt;
  int            m_run;
  bit            m_fired;

  function automatic void m_reset();
    m_hist = {};
    for (int i = 0; i < DEPTH; i++) m_hist.push_back('0);
    m_en_cnt = 0;
    m_run    = 0;
    m_fired  = 1'b0;
  endfunction

  function automatic logic [CH-1:0] m_out();
    return m_hist[0];
  endfunction

  function automatic bit m_valid();
    return m_en_cnt >= DEPTH;
  endfunction

  function automatic int m_cnt();
    return (m_run > THRESH) ? THRESH : m_run;
  endfunction

  function automatic int m_state();
    if (m_fired) return 2;
    return (m_run > 0) ? 1 : 0;
  endfunction

  function automatic void m_update(bit en, bit clr, logic [CH-1:0] a, logic [CH-1:0] b);
    bit cond;
    if (clr) begin
      m_reset();
      return;
    end
    if (!en) return;
    cond = m_valid() && (m_out() == {CH{1'b1}});
`ifdef NT_TRIG_STICKY_EN
    if (!m_fired) begin
      if (cond) begin
        m_run++;
        if (m_run >= THRESH) m_fired = 1'b1;
      end else begin
        m_run = 0;
      end
    end
`else
    if (cond) begin
      if (m_run < THRESH) m_run++;
      if (m_run >= THRESH) m_fired = 1'b1;
    end else begin
      m_run   = 0;
      m_fired = 1'b0;
    end
`endif
    m_hist.push_back(~(a & b));
    void'(m_hist.pop_front());
    if (m_en_cnt < DEPTH) m_en_cnt++;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [31:0] pack(logic [CH-1:0] o, logic v, logic [CNT_W-1:0] c,
                                       logic [1:0] s, logic t);
    return 32'({o, v, c, s, t});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic check_model();
    check("model {out,valid,cnt,state,trig}",
          pack(out_o, valid_o, cnt_o, state_o, trig_o),
          pack(m_out(), m_valid(), CNT_W'(m_cnt()), 2'(m_state()), m_fired));
  endtask

  // Model sees the pre-edge inputs, then the DUT is sampled 1 time unit after the edge.
  task automatic step();
    m_update(en_i, clr_i, a_i, b_i);
    @(posedge CLK);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic do_reset();
    en_i  = 1'b0;
    clr_i = 1'b0;
    a_i   = '0;
    b_i   = '0;
    RSTB  = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset state", pack(out_o, valid_o, cnt_o, state_o, trig_o), 32'd0);
    @(negedge CLK);
    RSTB = 1'b1;
    cyc  = 0;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic             en;
    logic             clr;
    logic [CH-1:0]    a;
    logic [CH-1:0]    b;
    logic [CH-1:0]    out;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;
    logic             trig;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    bit quiet;

    // From reset with a=b=0, en=1: row k is the expectation after the k-th edge.
    for (int k = 1; k <= 20; k++) begin
      vecs[k-1].en    = 1'b1;
      vecs[k-1].clr   = 1'b0;
      vecs[k-1].a     = '0;
      vecs[k-1].b     = '0;
      vecs[k-1].out   = (k >= DEPTH) ? {CH{1'b1}} : '0;
      vecs[k-1].valid = (k >= DEPTH);
      vecs[k-1].cnt   = CNT_W'((k <= DEPTH) ? 0 : ((k - DEPTH > THRESH) ? THRESH : k - DEPTH));
      vecs[k-1].state = (k >= DEPTH + THRESH) ? 2'd2 : ((k > DEPTH) ? 2'd1 : 2'd0);
      vecs[k-1].trig  = (k >= DEPTH + THRESH);
    end
    // Two frozen cycles with garbage operands: nothing may move.
    for (int k = 20; k < NVEC; k++) begin
      vecs[k].en    = 1'b0;
      vecs[k].clr   = 1'b0;
      vecs[k].a     = 4'hF;
      vecs[k].b     = 4'hF;
      vecs[k].out   = 4'hF;
      vecs[k].valid = 1'b1;
      vecs[k].cnt   = 8'd16;
      vecs[k].state = 2'd2;
      vecs[k].trig  = 1'b1;
    end

    // Latency and fire from the vector table.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      en_i  = vecs[i].en;
      clr_i = vecs[i].clr;
      a_i   = vecs[i].a;
      b_i   = vecs[i].b;
      step();
      check($sformatf("vec[%0d]", i), pack(out_o, valid_o, cnt_o, state_o, trig_o),
            pack(vecs[i].out, vecs[i].valid, vecs[i].cnt, vecs[i].state, vecs[i].trig));
    end

    // Asynchronous reset while FIRED: outputs clear before any clock edge.
    #2;
    RSTB = 1'b0;
    #1;
    check("async reset", pack(out_o, valid_o, cnt_o, state_o, trig_o), 32'd0);
    m_reset();
    #2;
    RSTB = 1'b1;
    cyc  = 0;

    // A single failing channel breaks the run once it reaches out_o.
    do_reset();
    en_i = 1'b1;
    repeat (12) step();
    check("break: cnt before", 32'(cnt_o), 32'd9);
    a_i = 4'b0001;
    b_i = 4'b0001;
    step();
    a_i = '0;
    b_i = '0;
    step();
    step();
    check("break: out bit0 low", 32'(out_o), 32'hE);
    check("break: cnt still counting", 32'(cnt_o), 32'd12);
    step();
    check("break: after", pack(out_o, valid_o, cnt_o, state_o, trig_o),
          pack(4'hF, 1'b1, 8'd0, 2'd0, 1'b0));

    // Enable freeze mid-count, then clear with enable low.
    repeat (3) step();
    check("freeze: cnt start", 32'(cnt_o), 32'd3);
    en_i = 1'b0;
    a_i  = 4'hF;
    b_i  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("freeze[%0d]: cnt", i), 32'(cnt_o), 32'd3);
    end
    en_i = 1'b1;
    a_i  = '0;
    b_i  = '0;
    step();
    check("freeze: resume", 32'(cnt_o), 32'd4);
    en_i  = 1'b0;
    clr_i = 1'b1;
    step();
    check("clear", pack(out_o, valid_o, cnt_o, state_o, trig_o), 32'd0);
    clr_i = 1'b0;

    // After firing, drop cond and see how FIRED responds.
    do_reset();
    en_i = 1'b1;
    repeat (DEPTH + THRESH) step();
    check("fire: trig", 32'(trig_o), 32'd1);
    a_i = 4'hF;
    b_i = 4'hF;
    repeat (DEPTH) step();
    check("drop: out zero, still fired", pack(out_o, trig_o, 1'b0, 2'd0, 1'b0),
          pack(4'h0, 1'b1, 1'b0, 2'd0, 1'b0));
    step();
`ifdef NT_TRIG_STICKY_EN
    check("drop: sticky", pack(4'h0, 1'b0, cnt_o, state_o, trig_o),
          pack(4'h0, 1'b0, 8'd16, 2'd2, 1'b1));
`else
    check("drop: released", pack(4'h0, 1'b0, cnt_o, state_o, trig_o),
          pack(4'h0, 1'b0, 8'd0, 2'd0, 1'b0));
`endif
    clr_i = 1'b1;
    step();
    check("drop: clear", 32'(trig_o), 32'd0);
    clr_i = 1'b0;

    // Randomized run: long mostly-qualifying windows so the trigger actually fires.
    do_reset();
    quiet = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) quiet = ($urandom_range(0, 2) != 0);
      en_i  = ($urandom_range(0, 9) < 8);
      clr_i = ($urandom_range(0, 299) == 0);
      a_i   = CH'($urandom);
      if (quiet) b_i = ($urandom_range(0, 99) == 0) ? CH'($urandom) : ~a_i;
      else       b_i = CH'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
